// File: rtl/conv_result_drain.sv
// conv_result_drain: captures the convolution processor's result writes into a
// local buffer and, on done, streams them out lowest address first over a
// valid/ready interface with a last-beat marker.
// Optional feature: define CONV_DRAIN_LENCHK_EN to compare the captured result
// count against sizeX_i+sizeY_i-1 and flag a mismatch on len_err_o.
module conv_result_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  writeZ_i,
  input  logic [ADDR_WIDTH-1:0] memZaddr_i,
  input  logic [DATA_WIDTH-1:0] dataZ_i,
  input  logic                  done_i,
  input  logic [4:0]            sizeX_i,
  input  logic [4:0]            sizeY_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  drain_done_o,
  output logic                  ovf_err_o,
  output logic                  len_err_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;  // holds 0..DEPTH

  typedef enum logic {CAPTURE = 1'b0, DRAIN = 1'b1} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] res_buf [DEPTH];
  logic [ADDR_WIDTH-1:0] hwm_q, hwm_d;
  logic                  hwm_valid_q, hwm_valid_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         rd_ptr_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q, m_last_q;
  logic                  drain_done_q, ovf_err_q, len_err_q;
  logic                  len_mismatch;
  logic                  load, hs_last;

  // High-water mark and run length as they would be after this cycle's write,
  // so a write coincident with done_i is counted.
  always_comb begin
    hwm_d       = hwm_q;
    hwm_valid_d = hwm_valid_q;
    if (writeZ_i) begin
      hwm_valid_d = 1'b1;
      if (!hwm_valid_q || (memZaddr_i > hwm_q)) hwm_d = memZaddr_i;
    end
    len_d = hwm_valid_d ? ({1'b0, hwm_d} + LW'(1)) : '0;
  end

`ifdef CONV_DRAIN_LENCHK_EN
  logic [5:0] exp_len;
  assign exp_len      = 6'({1'b0, sizeX_i} + {1'b0, sizeY_i}) - 6'd1;
  assign len_mismatch = (len_d != LW'(exp_len));
`else
  logic unused_sizes;
  assign unused_sizes = ^{sizeX_i, sizeY_i};
  assign len_mismatch = 1'b0;
`endif

  // Output register reloads whenever it is empty or being consumed.
  assign load    = (!m_valid_q || m_ready_i) && (rd_ptr_q < len_q);
  assign hs_last = m_valid_q && m_ready_i && m_last_q;

  // Result buffer: written only while capturing.
  // NOTE: the buffer has no reset; its contents are only ever read below the
  // high-water mark of a run, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (rstn && (state_q == CAPTURE) && writeZ_i) res_buf[memZaddr_i] <= dataZ_i;
  end

  // Control FSM with registered stream outputs and status flags.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= CAPTURE;
      hwm_q        <= '0;
      hwm_valid_q  <= 1'b0;
      len_q        <= '0;
      rd_ptr_q     <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      drain_done_q <= 1'b0;
      ovf_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      case (state_q)
        CAPTURE: begin
          hwm_q       <= hwm_d;
          hwm_valid_q <= hwm_valid_d;
          if (done_i) begin
            hwm_q       <= '0;
            hwm_valid_q <= 1'b0;
            len_q       <= len_d;
            rd_ptr_q    <= '0;
            if (len_mismatch) len_err_q <= 1'b1;
            if (len_d == '0) drain_done_q <= 1'b1;
            else             state_q      <= DRAIN;
          end
        end
        DRAIN: begin
          if (writeZ_i || done_i) ovf_err_q <= 1'b1;
          if (hs_last) begin
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            state_q      <= CAPTURE;
            drain_done_q <= 1'b1;
          end else if (load) begin
            m_data_q  <= res_buf[rd_ptr_q[ADDR_WIDTH-1:0]];
            m_valid_q <= 1'b1;
            m_last_q  <= (rd_ptr_q == (len_q - LW'(1)));
            rd_ptr_q  <= rd_ptr_q + LW'(1);
          end else if (m_valid_q && m_ready_i) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
          end
        end
        default: state_q <= CAPTURE;
      endcase
    end
  end

  assign m_data_o     = m_data_q;
  assign m_valid_o    = m_valid_q;
  assign m_last_o     = m_last_q;
  assign busy_o       = (state_q == DRAIN);
  assign drain_done_o = drain_done_q;
  assign ovf_err_o    = ovf_err_q;
  assign len_err_o    = len_err_q;

endmodule

// File: tb/tb_conv_result_drain.sv
// tb_conv_result_drain: randomized self-checking bench for conv_result_drain.
// The reference model is a plain array of the last word written per address
// plus the highest address seen; each run's expected stream is that array
// read from 0 up to the highest address.
module tb_conv_result_drain;

  logic        clk;
  logic        rstn;
  logic        writeZ_i;
  logic [5:0]  memZaddr_i;
  logic [15:0] dataZ_i;
  logic        done_i;
  logic [4:0]  sizeX_i, sizeY_i;
  logic [15:0] m_data_o;
  logic        m_valid_o, m_ready_i, m_last_o;
  logic        busy_o, drain_done_o, ovf_err_o, len_err_o;

  conv_result_drain #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .writeZ_i    (writeZ_i),
    .memZaddr_i  (memZaddr_i),
    .dataZ_i     (dataZ_i),
    .done_i      (done_i),
    .sizeX_i     (sizeX_i),
    .sizeY_i     (sizeY_i),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_last_o    (m_last_o),
    .busy_o      (busy_o),
    .drain_done_o(drain_done_o),
    .ovf_err_o   (ovf_err_o),
    .len_err_o   (len_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [15:0] ref_mem [64];
  int          ref_hwm     = -1;
  logic [15:0] exp_q [$];
  bit          exp_ovf     = 1'b0;
  bit          exp_len_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_write(input int addr, input logic [15:0] data);
    ref_mem[addr] = data;
    if (addr > ref_hwm) ref_hwm = addr;
  endtask

  // One capture-phase write, applied at a falling edge for the next rising edge.
  task automatic wr(input int addr, input logic [15:0] data);
    writeZ_i   = 1'b1;
    memZaddr_i = 6'(addr);
    dataZ_i    = data;
    model_write(addr, data);
    @(negedge clk);
    writeZ_i = 1'b0;
  endtask

  // done_i pulse, optionally with a coincident write; builds the expected stream.
  task automatic fire_done(input bit with_wr, input int addr, input logic [15:0] data);
    if (with_wr) begin
      writeZ_i   = 1'b1;
      memZaddr_i = 6'(addr);
      dataZ_i    = data;
      model_write(addr, data);
    end
    done_i = 1'b1;
    exp_q.delete();
    for (int i = 0; i <= ref_hwm; i++) exp_q.push_back(ref_mem[i]);
`ifdef CONV_DRAIN_LENCHK_EN
    if (exp_q.size() != ((int'(sizeX_i) + int'(sizeY_i) - 1) & 63)) exp_len_err = 1'b1;
`endif
    ref_hwm = -1;
    @(negedge clk);
    done_i   = 1'b0;
    writeZ_i = 1'b0;
  endtask

  // Consumes one run. mode 0: ready always high, 1: ready 1,0,0,1 pattern,
  // 2: random ready. inject_idx >= 0 pulses a write on that beat's handshake.
  task automatic run_drain(input int mode, input int inject_idx);
    int          n;
    int          idx;
    int          cyc;
    bit          stall;
    bit          dd_bad;
    bit          last_bad;
    logic [15:0] hold_d;
    logic        hold_l;
    n = exp_q.size(); idx = 0; cyc = 0; stall = 0; dd_bad = 0; last_bad = 0;
    hold_d = '0; hold_l = 1'b0;
    if (n == 0) begin
      check("empty_dd", drain_done_o, 1);
      check("empty_busy", busy_o, 0);
      check("empty_valid", m_valid_o, 0);
      @(negedge clk);
      check("empty_dd_pulse", drain_done_o, 0);
      return;
    end
    check("start_busy", busy_o, 1);
    check("start_valid", m_valid_o, 0);
    while (idx < n && cyc < 40 * n + 40) begin
      case (mode)
        0:       m_ready_i = 1'b1;
        1:       m_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: m_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (stall) begin
        check("stall_valid", m_valid_o, 1);
        check("stall_data", m_data_o, hold_d);
        check("stall_last", m_last_o, hold_l);
      end
      if (mode == 0 && cyc >= 1) check("tput_valid", m_valid_o, 1);
      if (drain_done_o) dd_bad = 1'b1;
      if (!m_valid_o && m_last_o) last_bad = 1'b1;
      if (m_valid_o && m_ready_i) begin
        check("beat_data", m_data_o, exp_q[idx]);
        check("beat_last", m_last_o, (idx == n - 1));
        if (idx == inject_idx) begin
          writeZ_i   = 1'b1;
          memZaddr_i = (idx + 1 < n) ? 6'(idx + 1) : 6'd63;
          dataZ_i    = ~ref_mem[(idx + 1 < n) ? idx + 1 : 63];
          exp_ovf    = 1'b1;
        end
        idx++;
        stall = 1'b0;
      end else begin
        stall  = m_valid_o;
        hold_d = m_data_o;
        hold_l = m_last_o;
      end
      @(negedge clk);
      writeZ_i = 1'b0;
      cyc++;
    end
    check("beats_done", idx, n);
    check("no_early_dd", dd_bad, 0);
    check("last_only_valid", last_bad, 0);
    if (mode == 0) check("drain_cycles", cyc, n + 1);
    check("end_dd", drain_done_o, 1);
    check("end_busy", busy_o, 0);
    check("end_valid", m_valid_o, 0);
    m_ready_i = 1'b0;
    @(negedge clk);
    check("dd_one_pulse", drain_done_o, 0);
    check("ovf", ovf_err_o, exp_ovf);
    check("len_err", len_err_o, exp_len_err);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nw, hi, inj, mode;
    rstn = 1'b0; writeZ_i = 1'b0; memZaddr_i = '0; dataZ_i = '0; done_i = 1'b0;
    sizeX_i = 5'd0; sizeY_i = 5'd0; m_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    m_ready_i = 1'b1;

    // Idle after reset: everything quiet even with ready high.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_outputs", {m_data_o, m_valid_o, m_last_o, busy_o, drain_done_o,
                             ovf_err_o, len_err_o}, 0);
    end
    m_ready_i = 1'b0;

    // Five results, full-rate consumer.
    for (int a = 0; a < 5; a++) wr(a, 16'h0010 + 16'(a));
    fire_done(1'b0, 0, '0);
    run_drain(0, -1);

    // Same five results, stalling consumer.
    for (int a = 0; a < 5; a++) wr(a, 16'h0010 + 16'(a));
    fire_done(1'b0, 0, '0);
    run_drain(1, -1);

    // done with nothing captured.
    fire_done(1'b0, 0, '0);
    run_drain(0, -1);

    // Full buffer, final write coincident with done.
    for (int a = 0; a < 63; a++) wr(a, 16'($urandom));
    fire_done(1'b1, 63, 16'hBEEF);
    run_drain(0, -1);

    // Overwrite: last write to an address wins.
    wr(0, 16'hA000); wr(1, 16'hA001); wr(2, 16'h1111); wr(2, 16'h2222);
    fire_done(1'b0, 0, '0);
    run_drain(2, -1);

    // Writes during drain: mid-stream and on the final handshake edge.
    for (int a = 0; a < 6; a++) wr(a, 16'($urandom));
    fire_done(1'b0, 0, '0);
    run_drain(0, 1);
    for (int a = 0; a < 4; a++) wr(a, 16'($urandom));
    fire_done(1'b0, 0, '0);
    run_drain(0, 3);
    wr(0, 16'h5A5A); wr(1, 16'hA5A5);
    fire_done(1'b0, 0, '0);
    run_drain(0, -1);

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      sizeX_i = 5'($urandom); sizeY_i = 5'($urandom);
      nw = $urandom_range(1, 20);
      hi = $urandom_range(0, 63);
      for (int w = 0; w < nw; w++) wr($urandom_range(0, hi), 16'($urandom));
      if ($urandom_range(0, 1) == 1) fire_done(1'b1, $urandom_range(0, hi), 16'($urandom));
      else                           fire_done(1'b0, 0, '0);
      inj  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, exp_q.size() - 1) : -1;
      mode = $urandom_range(0, 2);
      run_drain(mode, inj);
    end

`ifdef CONV_DRAIN_LENCHK_EN
    sizeX_i = 5'd3; sizeY_i = 5'd4;
    for (int a = 0; a < 6; a++) wr(a, 16'($urandom));
    fire_done(1'b0, 0, '0);
    run_drain(0, -1);
    for (int a = 0; a < 5; a++) wr(a, 16'($urandom));
    fire_done(1'b0, 0, '0);
    run_drain(1, -1);
`endif

    // Reset in the middle of a drain.
    for (int a = 0; a < 10; a++) wr(a, 16'($urandom));
    fire_done(1'b0, 0, '0);
    m_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_valid_before_rst", m_valid_o, 1);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_valid", m_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_dd", drain_done_o, 0);
    check("rst_ovf", ovf_err_o, 0);
    exp_ovf = 1'b0; exp_len_err = 1'b0; ref_hwm = -1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_dd", drain_done_o, 0);
      check("post_rst_valid", m_valid_o, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_result_drain.md
# conv_result_drain

Downstream stage of the convolution processor. It captures every result word the processor writes (`writeZ`/`memZaddr`/`dataZ`) into a local 64×16 buffer. On the processor's `done` pulse it streams the captured results out, lowest address first, over a valid/ready interface with a last-beat marker. It decouples the processor from a slow consumer, for example a host read port or a DMA.

## Interface

Parameters:
- `DATA_WIDTH`, 16: result word width; matches `dataZ`.
- `ADDR_WIDTH`, 6: result address width; buffer depth is `2**ADDR_WIDTH` (64).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rstn`  in  1  reset, synchronous and active-low.
- `writeZ_i`  in  1  result write strobe from the processor.
- `memZaddr_i`  in  ADDR_WIDTH  result address.
- `dataZ_i`  in  DATA_WIDTH  result data.
- `done_i`  in  1  one-cycle pulse from the processor: the result set is complete.
- `sizeX_i`  in  5  X length; used only with the length check.
- `sizeY_i`  in  5  Y length; used only with the length check.
- `m_data_o`  out  DATA_WIDTH  streamed result word.
- `m_valid_o`  out  1  `m_data_o` is valid.
- `m_ready_i`  in  1  consumer accepts the word.
- `m_last_o`  out  1  current beat is the final result.
- `busy_o`  out  1  high while in DRAIN.
- `drain_done_o`  out  1  one-cycle pulse after the final beat is accepted.
- `ovf_err_o`  out  1  sticky: a write or `done_i` arrived during DRAIN.
- `len_err_o`  out  1  sticky: the length check failed (see Configuration).

## Operation

- State machine: CAPTURE (reset state) and DRAIN.
- Reset (`rstn`=0 at an edge):
  - state=CAPTURE; `hwm_valid`=0, `hwm`=0, `rd_ptr`=0.
  - All outputs 0.
  - Buffer contents are not reset.
- CAPTURE, `writeZ_i`=1:
  - `buf[memZaddr_i] <= dataZ_i`; a repeated address overwrites (last write wins).
  - `hwm <= max(hwm, memZaddr_i)`; `hwm_valid <= 1`.
- CAPTURE, `done_i`=1:
  - Latch `len = hwm_valid ? hwm+1 : 0`, 7 bits (range 0..64).
  - If `writeZ_i` is high in the same cycle, that write is included in `len` and `hwm` is computed with it.
  - `len`=0: stay in CAPTURE and pulse `drain_done_o` next cycle; nothing is streamed.
  - `len`>0: go to DRAIN, `rd_ptr`=0.
  - In both cases `hwm_valid` and `hwm` clear, ready for the next run.
- DRAIN:
  - Single output register. It loads `buf[rd_ptr]` (combinational array read) when `!m_valid_o || m_ready_i`, provided `rd_ptr < len`. The load sets `m_valid_o` and increments `rd_ptr`.
  - `m_last_o` = `m_valid_o` and the held word is index `len-1`.
  - While `m_valid_o && !m_ready_i`, `m_data_o` and `m_last_o` hold stable.
  - `m_valid_o` never drops without a handshake.
  - A handshake on the last beat clears `m_valid_o`, returns to CAPTURE and pulses `drain_done_o` on the following cycle.
- DRAIN, `writeZ_i` or `done_i` arriving:
  - Ignored: no buffer write, no `hwm` update.
  - Sets `ovf_err_o`.
- Mid-operation `rstn`: aborts the drain immediately; no `drain_done_o`.
- Width rules:
  - `hwm+1` and `len` are computed in ADDR_WIDTH+1 bits.
  - The read address is `rd_ptr[ADDR_WIDTH-1:0]`; `rd_ptr` is 7 bits and never wraps.

## Timing

- `done_i` at edge T: `busy_o`=1 from T+1; first `m_valid_o`=1 from T+2.
- Back-to-back throughput: 1 word per cycle with `m_ready_i` held high.
- N results with `m_ready_i`=1 throughout:
  - Beats at T+2..T+N+1.
  - `busy_o` falls at T+N+2.
  - `drain_done_o` is high during cycle T+N+2.
- A write in the cycle state returns to CAPTURE (same edge as the final handshake) is still in DRAIN, so it is rejected and flagged.
- Writes are accepted from the next cycle.

## Configuration

- `CONV_DRAIN_LENCHK_EN` defined:
  - At `done_i` acceptance, compare `len` with `sizeX_i+sizeY_i-1`, evaluated in 6 bits.
  - On mismatch set `len_err_o` (sticky until reset). Draining proceeds using `len` regardless.
- Not defined: `len_err_o` is tied to 0; `sizeX_i` and `sizeY_i` are unused.

## Test plan

- Reset, then idle: every output is 0 for 5 cycles, including with `m_ready_i`=1.
- Write addr 0..4 with data 0x0010..0x0014, then `done_i` with `m_ready_i`=1:
  - Exactly 5 consecutive beats 0x0010..0x0014.
  - `m_last_o` only on 0x0014.
  - `drain_done_o` pulses once.
- Same run with `m_ready_i` toggling 1,0,0,1,…:
  - Data holds stable during stalls; the same 5 words arrive in order with none lost or duplicated.
- Overlap and overwrite:
  - Write addr 63 = 0xBEEF together with `done_i` in one cycle: 64 beats, and the last is 0xBEEF.
  - Write addr 2 twice (0x1111 then 0x2222): 0x2222 is streamed.
- `writeZ_i` pulse during DRAIN:
  - `ovf_err_o`=1; stream contents unchanged.
  - `rstn`=0 mid-drain: `m_valid_o` and `busy_o` are 0 the next cycle, and no `drain_done_o` pulse occurs.
- With `CONV_DRAIN_LENCHK_EN`:
  - sizeX=3, sizeY=4, 6 writes, `done_i`: `len_err_o` is 0.
  - sizeX=3, sizeY=4, 5 writes, `done_i`: `len_err_o` is 1, and 5 beats are still streamed.
